// File: rtl/m_conv_param_if.sv
// m_conv_param_if: tap-in / pixel-out handshake bundle for the convolution MAC
interface m_conv_param_if #(parameter int DW = 16);
  logic start, in_valid, in_ready, out_valid, busy, ready;
  logic signed [DW-1:0] map_in, k_in, map_out;
  modport master (output start, in_valid, map_in, k_in, input in_ready, out_valid, map_out, busy, ready);
  modport slave (input start, in_valid, map_in, k_in, output in_ready, out_valid, map_out, busy, ready);
endinterface

// File: rtl/m_conv_param.sv
// m_conv_param: streaming MAC, NUM_KERNEL taps per pixel, rounded/saturated/optional ReLU output
module m_conv_param #(
  parameter int DW = 16,
  parameter int FRAC = 12,
  parameter int NUM_KERNEL = 25,
  parameter int NUM_OUT = 324,
  parameter int MULT_LAT = 2,
  parameter int RELU = 0
) (
  input logic clk_in,
  input logic rst_n,
  m_conv_param_if.slave bus
);
  localparam int ACC_W = 2 * DW + $clog2(NUM_KERNEL) + 1;
  localparam int TOTAL = NUM_OUT * NUM_KERNEL;
  localparam int TW = $clog2(TOTAL + 1);
  localparam int KW = $clog2(NUM_KERNEL + 1);
  localparam int OW = $clog2(NUM_OUT + 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [TW-1:0] tap_cnt;
  logic [KW-1:0] k_cnt;
  logic [OW-1:0] out_cnt;
  logic signed [2*DW-1:0] p_q [MULT_LAT];
  logic [MULT_LAT-1:0] v_q;
  logic signed [ACC_W-1:0] acc, sum, rnd;
  logic [DW-1:0] sat, res;
  logic accept, clr, last_k, emit, out_valid_q;
  logic [DW-1:0] map_out_q;

  assign accept = bus.in_valid && state == RUN;
  assign clr = bus.start && (state == IDLE || state == DONE);
  assign last_k = k_cnt == KW'(NUM_KERNEL - 1);
  assign emit = v_q[MULT_LAT-1] && last_k;
  assign sum = acc + {{(ACC_W-2*DW){p_q[MULT_LAT-1][2*DW-1]}}, p_q[MULT_LAT-1]};
  assign rnd = (sum + HALF) >>> FRAC;
  assign sat = rnd >= SMAX ? SMAX[DW-1:0] : rnd <= SMIN ? SMIN[DW-1:0] : rnd[DW-1:0];
  assign res = (RELU != 0 && sat[DW-1]) ? '0 : sat;

  assign bus.in_ready = state == RUN;
  assign bus.busy = state == RUN || state == DRAIN;
  assign bus.ready = state != DONE;
  assign bus.out_valid = out_valid_q;
  assign bus.map_out = map_out_q;

  // frame state register
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // frame sequencing: start, last tap accepted, last pixel emitted
  always_comb begin
    state_nx = state;
    if (clr) state_nx = RUN;
    else if (accept && tap_cnt == TW'(TOTAL - 1)) state_nx = DRAIN;
    else if (state == DRAIN && out_valid_q && out_cnt == OW'(NUM_OUT)) state_nx = DONE;
  end

  // multiplier pipe, accumulator, counters and output register
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) p_q[i] <= '0;
      v_q <= '0;
      tap_cnt <= '0;
      k_cnt <= '0;
      out_cnt <= '0;
      acc <= '0;
      out_valid_q <= 1'b0;
      map_out_q <= '0;
    end else begin
      v_q[0] <= accept;
      p_q[0] <= $signed(bus.map_in) * $signed(bus.k_in);
      for (int i = 1; i < MULT_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        p_q[i] <= p_q[i-1];
      end
      out_valid_q <= emit;
      if (emit) map_out_q <= res;
      if (clr) begin
        tap_cnt <= '0;
        k_cnt <= '0;
        out_cnt <= '0;
        acc <= '0;
      end else begin
        if (accept) tap_cnt <= tap_cnt + 1'b1;
        if (v_q[MULT_LAT-1]) begin
          k_cnt <= last_k ? '0 : k_cnt + 1'b1;
          acc <= last_k ? '0 : sum;
        end
        if (emit) out_cnt <= out_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_m_conv_param.sv
// tb_m_conv_param: table-driven scoreboard bench over three parameterisations of m_conv_param
module tb_m_conv_param;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [2:0] st, vl, ov, ir, rd, bz;
  logic signed [15:0] mp [3];
  logic signed [15:0] kk [3];
  logic signed [15:0] mo [3];

  for (genvar g = 0; g < 3; g++) begin : d
    m_conv_param_if #(.DW(16)) b ();
    assign b.start = st[g];
    assign b.in_valid = vl[g];
    assign b.map_in = mp[g];
    assign b.k_in = kk[g];
    assign ov[g] = b.out_valid;
    assign ir[g] = b.in_ready;
    assign rd[g] = b.ready;
    assign bz[g] = b.busy;
    assign mo[g] = b.map_out;
    m_conv_param #(
      .DW(16), .FRAC(12), .MULT_LAT(2),
      .NUM_KERNEL(g == 1 ? 1 : 3),
      .NUM_OUT(g == 0 ? 2 : g == 1 ? 4 : 1),
      .RELU(g == 2 ? 1 : 0)
    ) u (.clk_in(clk_in), .rst_n(rst_n), .bus(b));
  end

  int kn [3] = '{3, 1, 3};
  int nout [3] = '{2, 4, 1};

  typedef struct {int id; int m; int k; int e; bit gap;} vec_t;
  typedef struct {int id; int v;} exp_t;
  vec_t tbl [13];
  exp_t q [$];
  int checks = 0;
  int errors = 0;
  int last_ov [3] = '{0, 0, 0};
  int last_v [3] = '{0, 0, 0};
  int cnt [3] = '{0, 0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard: every out_valid pops the oldest expected pixel
  always @(negedge clk_in)
    for (int i = 0; i < 3; i++)
      if (rst_n && ov[i]) begin
        if (q.size() == 0) chk($sformatf("unexpected_out_dut%0d", i), int'(mo[i]), 99999);
        else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("dut_id_of_out%0d", i), i, e.id);
          chk($sformatf("map_out_dut%0d", i), int'(mo[i]), e.v);
          last_ov[i] = cyc;
          last_v[i] = e.v;
        end
      end

  task automatic tap(input int id, input int m, input int k, input bit gap, output int tc);
    int w;
    if (gap) begin
      vl[id] = 1'b0;
      @(negedge clk_in);
    end
    w = 0;
    while (!ir[id] && w < 50) begin
      @(negedge clk_in);
      w++;
    end
    if (w == 50) chk("tap_wait_timeout", 0, 1);
    mp[id] = 16'(m);
    kk[id] = 16'(k);
    vl[id] = 1'b1;
    tc = cyc;
    @(negedge clk_in);
  endtask

  task automatic do_start(input int id);
    vl[id] = 1'b0;
    st[id] = 1'b1;
    @(negedge clk_in);
    st[id] = 1'b0;
    chk("in_ready_after_start", int'(ir[id]), 1);
    chk("busy_after_start", int'(bz[id]), 1);
    chk("ready_after_start", int'(rd[id]), 1);
  endtask

  task automatic end_frame(input int id);
    int w;
    vl[id] = 1'b0;
    w = 0;
    while (rd[id] && w < 200) begin
      @(negedge clk_in);
      w++;
    end
    if (w == 200) chk("ready_fall_timeout", 0, 1);
    else chk("ready_fall_delay", cyc - last_ov[id], 1);
    chk("busy_in_done", int'(bz[id]), 0);
    chk("in_ready_in_done", int'(ir[id]), 0);
    chk("map_out_hold", int'(mo[id]), last_v[id]);
  endtask

  initial begin
    int tc, w;
    st = '0;
    vl = '0;
    for (int i = 0; i < 3; i++) begin
      mp[i] = '0;
      kk[i] = '0;
    end
    tbl[0] = '{0, 4096, 4096, 12288, 1'b0};
    tbl[1] = '{0, 4096, 4096, 12288, 1'b0};
    tbl[2] = '{0, 4096, 4096, 12288, 1'b1};
    tbl[3] = '{0, 4096, 4096, 12288, 1'b1};
    tbl[4] = '{0, 32767, 32767, 32767, 1'b0};
    tbl[5] = '{0, -32768, 32767, -32768, 1'b0};
    tbl[6] = '{1, 1, 2048, 1, 1'b0};
    tbl[7] = '{1, -1, 2048, 0, 1'b0};
    tbl[8] = '{1, -1, 2049, -1, 1'b0};
    tbl[9] = '{1, 1, 2047, 0, 1'b0};
    tbl[10] = '{2, -4096, 4096, 0, 1'b0};
    tbl[11] = '{0, -4096, 4096, -12288, 1'b0};
    tbl[12] = '{0, 100, -200, -15, 1'b0};
    repeat (3) @(negedge clk_in);
    chk("rst_in_ready", int'(ir), 0);
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_busy", int'(bz), 0);
    chk("rst_ready", int'(rd), 7);
    for (int i = 0; i < 3; i++) chk("rst_map_out", int'(mo[i]), 0);
    rst_n = 1'b1;
    @(negedge clk_in);
    // taps offered in IDLE must be dropped
    vl[0] = 1'b1;
    mp[0] = 16'sd4096;
    kk[0] = 16'sd4096;
    repeat (5) @(negedge clk_in);
    chk("in_ready_idle", int'(ir[0]), 0);
    vl[0] = 1'b0;
    // latency of first pixel, with a start pulse in RUN that must be ignored
    do_start(0);
    tap(0, 4096, 4096, 1'b0, tc);
    vl[0] = 1'b0;
    st[0] = 1'b1;
    @(negedge clk_in);
    st[0] = 1'b0;
    tap(0, 4096, 4096, 1'b0, tc);
    tap(0, 4096, 4096, 1'b0, tc);
    q.push_back('{0, 12288});
    vl[0] = 1'b0;
    w = 0;
    while (!ov[0] && w < 20) begin
      @(negedge clk_in);
      w++;
    end
    chk("first_out_latency", cyc - tc, 3);
    for (int t = 0; t < 3; t++) tap(0, 4096, 4096, 1'b1, tc);
    q.push_back('{0, 12288});
    end_frame(0);
    // table of pixels; frames start and close per DUT
    for (int r = 0; r < 13; r++) begin
      int id;
      id = tbl[r].id;
      if (cnt[id] == 0) do_start(id);
      for (int t = 0; t < kn[id]; t++) tap(id, tbl[r].m, tbl[r].k, tbl[r].gap, tc);
      q.push_back('{id, tbl[r].e});
      cnt[id]++;
      if (cnt[id] == nout[id]) begin
        end_frame(id);
        cnt[id] = 0;
      end
    end
    // taps offered in DONE must be dropped
    vl[0] = 1'b1;
    mp[0] = 16'sd1000;
    kk[0] = 16'sd1000;
    repeat (6) @(negedge clk_in);
    vl[0] = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("ready_hold_done", int'(rd[0]), 0);
    // reset mid-frame after 4 of 6 taps
    do_start(0);
    for (int t = 0; t < 3; t++) tap(0, 4096, 4096, 1'b0, tc);
    q.push_back('{0, 12288});
    tap(0, 4096, 4096, 1'b0, tc);
    rst_n = 1'b0;
    vl[0] = 1'b0;
    #1;
    chk("midrst_in_ready", int'(ir[0]), 0);
    chk("midrst_out_valid", int'(ov[0]), 0);
    chk("midrst_map_out", int'(mo[0]), 0);
    chk("midrst_busy", int'(bz[0]), 0);
    chk("midrst_ready", int'(rd[0]), 1);
    q.delete();
    last_v[0] = 0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_in);
    chk("post_rst_busy", int'(bz[0]), 0);
    chk("post_rst_ready", int'(rd[0]), 1);
    do_start(0);
    for (int t = 0; t < 3; t++) tap(0, 4096, 4096, 1'b0, tc);
    q.push_back('{0, 12288});
    for (int t = 0; t < 3; t++) tap(0, 4096, 4096, 1'b0, tc);
    q.push_back('{0, 12288});
    end_frame(0);
    chk("leftover_expected", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
